// File: rtl/timer_apb_regs.sv
// -----------------------------------------------------------------------------
// timer_apb_regs
//   APB3 completer register block for the 8-bit timer. It holds TDR (load
//   value), TCR (control) and TSR (sticky overflow/underflow status). It also
//   drives the load/enable/direction/clock-select controls into the counter
//   core.
//
//   Register map (byte addresses):
//     0x00 TDR  rw  load value
//     0x01 TCR  rw  bit7 load, bit5 down, bit4 en, bits1:0 cks
//                   (bits 6,3,2 read 0)
//     0x02 TSR  w0c bit0 OVF, bit1 UDF (write 0 clears, write 1 keeps)
//     others        pslverr=1, write discarded, read 0x00
//
// Ports:
//   pclk, preset            clock, synchronous active-high reset
//   psel, penable, pwrite   APB control
//   paddr, pwdata           APB address / write data (8 bit)
//   prdata, pready, pslverr APB response, all registered
//   ovf_pulse, udf_pulse    one-cycle events from the counter core
//   tdr, load, en, down, cks  controls to the counter core
//
// Parameter:
//   WAIT_STATES  extra ACCESS cycles (0..3) before pready asserts
// -----------------------------------------------------------------------------
module timer_apb_regs #(
   parameter int WAIT_STATES = 0
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       psel,
   input  logic       penable,
   input  logic       pwrite,
   input  logic [7:0] paddr,
   input  logic [7:0] pwdata,
   output logic [7:0] prdata,
   output logic       pready,
   output logic       pslverr,
   input  logic       ovf_pulse,
   input  logic       udf_pulse,
   output logic [7:0] tdr,
   output logic       load,
   output logic       en,
   output logic       down,
   output logic [1:0] cks
);

   localparam logic [1:0] WS = WAIT_STATES[1:0];

   // Writable TCR bits: 7 (load), 5 (down), 4 (en), 1:0 (cks).
   localparam logic [7:0] TCR_MASK = 8'hB3;

   // state_reg names the bus phase recognised at the last clock edge.
   //   SETUP  : a setup cycle was just sampled; this is the first ACCESS cycle.
   //   ACCESS : later ACCESS cycles (wait states).
   // pready is registered, so the setup cycle is decoded from IDLE while it
   // is on the bus. This keeps a zero-wait transfer at two cycles.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t     state_reg;
   logic [1:0] cnt_reg;

   logic [7:0] tdr_reg, tdr_next;
   logic [7:0] tcr_reg, tcr_next;
   logic [1:0] tsr_reg, tsr_next;

   logic [7:0] prdata_reg;
   logic       pready_reg;
   logic       pslverr_reg;
   logic       load_reg;

   logic       access_ok;
   logic       addr_err;
   logic       commit;
   logic [7:0] rd_data;
   logic [1:0] cnt_inc;

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   always_comb begin
      access_ok = (state_reg != IDLE) && psel && penable;
      addr_err  = (paddr > 8'h02);
      // A write lands only on the edge that ends the pready cycle.
      // A transfer aborted by psel dropping never commits.
      commit    = access_ok && pready_reg && pwrite && !addr_err;
      cnt_inc   = cnt_reg + 2'd1;
   end

   // Next register values, including this edge's commit and events.
   always_comb begin
      tdr_next = tdr_reg;
      tcr_next = tcr_reg;
      tsr_next = tsr_reg;
      if (commit) begin
         case (paddr)
            8'h00:   tdr_next = pwdata;
            8'h01:   tcr_next = pwdata & TCR_MASK;
            8'h02:   tsr_next = tsr_reg & pwdata[1:0];
            default: ;
         endcase
      end
      // Core events are applied after the clear, so an event wins over a
      // clear written in the same cycle.
      tsr_next = tsr_next | {udf_pulse, ovf_pulse};
   end

   // The response is registered one edge ahead of the pready cycle.
   // Reading the next-state values keeps an event from the previous cycle
   // visible on the read.
   always_comb begin
      case (paddr)
         8'h00:   rd_data = tdr_next;
         8'h01:   rd_data = tcr_next;
         8'h02:   rd_data = {6'b000000, tsr_next};
         default: rd_data = 8'h00;
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers and transfer FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_reg   <= IDLE;
         cnt_reg     <= 2'd0;
         tdr_reg     <= 8'h00;
         tcr_reg     <= 8'h00;
         tsr_reg     <= 2'b00;
         prdata_reg  <= 8'h00;
         pready_reg  <= 1'b0;
         pslverr_reg <= 1'b0;
         load_reg    <= 1'b0;
      end else begin
         tdr_reg     <= tdr_next;
         tcr_reg     <= tcr_next;
         tsr_reg     <= tsr_next;
         load_reg    <= commit && (paddr == 8'h01) && pwdata[7];

         // pready/prdata/pslverr default low, so each is high for one cycle.
         pready_reg  <= 1'b0;
         pslverr_reg <= 1'b0;
         prdata_reg  <= 8'h00;

         case (state_reg)
            IDLE: begin
               if (psel && !penable) begin
                  state_reg <= SETUP;
                  cnt_reg   <= 2'd0;
                  if (WS == 2'd0) begin
                     pready_reg  <= 1'b1;
                     pslverr_reg <= addr_err;
                     prdata_reg  <= rd_data;
                  end
               end
            end

            SETUP, ACCESS: begin
               if (!access_ok) begin
                  // psel dropped (or penable missing): abandon the transfer.
                  state_reg <= IDLE;
               end else if (pready_reg) begin
                  // Transfer completes on this edge. A following setup
                  // cycle is picked up from IDLE, so no idle cycle is
                  // needed between transfers.
                  state_reg <= IDLE;
               end else begin
                  state_reg <= ACCESS;
                  cnt_reg   <= cnt_inc;
                  if (cnt_inc == WS) begin
                     pready_reg  <= 1'b1;
                     pslverr_reg <= addr_err;
                     prdata_reg  <= rd_data;
                  end
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign prdata  = prdata_reg;
   assign pready  = pready_reg;
   assign pslverr = pslverr_reg;
   assign tdr     = tdr_reg;
   assign load    = load_reg;
   assign en      = tcr_reg[4];
   assign down    = tcr_reg[5];
   assign cks     = tcr_reg[1:0];

endmodule

// File: tb/tb_timer_apb_regs.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_regs
//   Directed bench for timer_apb_regs. It uses two instances: dut0 with no
//   wait states and dut2 with WAIT_STATES=2. Both share the bus and the event
//   inputs and have their own select and reset. Each task covers one feature
//   and checks against hand-computed values.
// -----------------------------------------------------------------------------
module tb_timer_apb_regs;

   logic       clk = 1'b0;
   logic       preset0 = 1'b1;
   logic       preset2 = 1'b1;
   logic       psel0 = 1'b0;
   logic       psel2 = 1'b0;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] paddr = 8'h00;
   logic [7:0] pwdata = 8'h00;
   logic       ovf_pulse = 1'b0;
   logic       udf_pulse = 1'b0;

   logic [7:0] prdata0, prdata2, tdr0, tdr2;
   logic       pready0, pready2, pslverr0, pslverr2;
   logic       load0, load2, en0, en2, down0, down2;
   logic [1:0] cks0, cks2;

   int errors = 0;
   int checks = 0;

   // Results of the most recent transfer.
   logic [7:0] x_data;
   logic       x_err;
   int         x_cycles;

   always #5 clk = ~clk;

   timer_apb_regs #(.WAIT_STATES(0)) dut0 (
      .pclk(clk), .preset(preset0), .psel(psel0), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse),
      .tdr(tdr0), .load(load0), .en(en0), .down(down0), .cks(cks0)
   );

   timer_apb_regs #(.WAIT_STATES(2)) dut2 (
      .pclk(clk), .preset(preset2), .psel(psel2), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata2), .pready(pready2), .pslverr(pslverr2),
      .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse),
      .tdr(tdr2), .load(load2), .en(en2), .down(down2), .cks(cks2)
   );

   // One APB transfer to dut0 (which=0) or dut2 (which=1). It is entered
   // just after a rising edge and drives the setup cycle at once. It returns
   // one tick after the completing edge with psel low, so a following call
   // runs back-to-back. With ovf_at_done set, ovf_pulse is high during the
   // pready cycle.
   task automatic xfer(input bit which, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, input bit ovf_at_done);
      int  n;
      bit  done;
      if (which) psel2 = 1'b1; else psel0 = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      @(posedge clk); #1;
      penable = 1'b1;
      n    = 2;
      done = 1'b0;
      x_data = 8'h00;
      x_err  = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
         @(negedge clk);
         if ((which ? pready2 : pready0) === 1'b1) begin
            done   = 1'b1;
            x_data = which ? prdata2 : prdata0;
            x_err  = which ? pslverr2 : pslverr0;
            if (ovf_at_done) ovf_pulse = 1'b1;
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL xfer_timeout dut%0d addr=%h: pready never seen, required within 10 cycles", which, a);
      end
      @(posedge clk); #1;
      ovf_pulse = 1'b0;
      psel0     = 1'b0;
      psel2     = 1'b0;
      penable   = 1'b0;
      x_cycles  = n;
      $display("xfer dut%0d %s addr=%h wdata=%h rdata=%h err=%0d cycles=%0d",
               which, wr ? "WR" : "RD", a, d, x_data, x_err, n);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      preset0 = 1'b1;
      preset2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      preset0 = 1'b0;
      preset2 = 1'b0;
      checks++;
      if ({pready0, pslverr0, prdata0} !== 10'h000) begin
         errors++;
         $display("FAIL reset_bus: pready/pslverr/prdata=%b/%b/%h, required 0/0/00", pready0, pslverr0, prdata0);
      end
      checks++;
      if ({tdr0, load0, en0, down0, cks0} !== 13'h0) begin
         errors++;
         $display("FAIL reset_ctrl: tdr=%h load=%b en=%b down=%b cks=%b, required all 0", tdr0, load0, en0, down0, cks0);
      end
      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, 1'b0, i[7:0], 8'h00, 1'b0);
         checks++;
         if (x_data !== 8'h00 || x_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_read addr=%0d: data=%h err=%b, required 00/0", i, x_data, x_err);
         end
      end
   endtask

   task automatic test_ctrl_write();
      xfer(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
      checks++;
      if (tdr0 !== 8'hFF || load0 !== 1'b0) begin
         errors++;
         $display("FAIL tdr_write: tdr=%h load=%b, required FF/0", tdr0, load0);
      end
      xfer(1'b0, 1'b1, 8'h01, 8'h80, 1'b0);
      checks++;
      if (load0 !== 1'b1 || en0 !== 1'b0) begin
         errors++;
         $display("FAIL load_pulse: load=%b en=%b, required 1/0", load0, en0);
      end
      idle(1);
      checks++;
      if (load0 !== 1'b0) begin
         errors++;
         $display("FAIL load_width: load=%b one cycle later, required 0", load0);
      end
      xfer(1'b0, 1'b1, 8'h01, 8'h30, 1'b0);
      checks++;
      if ({load0, en0, down0, cks0} !== 5'b01100) begin
         errors++;
         $display("FAIL tcr_ctrl: load=%b en=%b down=%b cks=%b, required 0/1/1/00", load0, en0, down0, cks0);
      end
      xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h30) begin
         errors++;
         $display("FAIL tcr_read: data=%h, required 30", x_data);
      end
      // Reserved bits are dropped, and bit7 reads back as written.
      xfer(1'b0, 1'b1, 8'h01, 8'hFF, 1'b0);
      checks++;
      if (load0 !== 1'b1 || cks0 !== 2'b11) begin
         errors++;
         $display("FAIL tcr_full: load=%b cks=%b, required 1/11", load0, cks0);
      end
      xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'hB3) begin
         errors++;
         $display("FAIL tcr_reserved: data=%h, required B3", x_data);
      end
   endtask

   task automatic test_status();
      udf_pulse = 1'b1;
      idle(1);
      udf_pulse = 1'b0;
      xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h02) begin
         errors++;
         $display("FAIL tsr_udf: data=%h, required 02", x_data);
      end
      xfer(1'b0, 1'b1, 8'h02, 8'h00, 1'b0);
      xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h00) begin
         errors++;
         $display("FAIL tsr_clear: data=%h, required 00", x_data);
      end
      xfer(1'b0, 1'b1, 8'h02, 8'hFF, 1'b0);
      xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h00) begin
         errors++;
         $display("FAIL tsr_write1: data=%h, required 00", x_data);
      end
   endtask

   task automatic test_same_cycle();
      udf_pulse = 1'b1;
      idle(1);
      udf_pulse = 1'b0;
      // The clear write drops UDF, but OVF arriving at the commit survives.
      xfer(1'b0, 1'b1, 8'h02, 8'h00, 1'b1);
      xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h01) begin
         errors++;
         $display("FAIL tsr_event_wins: data=%h, required 01", x_data);
      end
   endtask

   task automatic test_error();
      xfer(1'b0, 1'b1, 8'h05, 8'hAA, 1'b0);
      checks++;
      if (x_err !== 1'b1 || tdr0 !== 8'hFF || load0 !== 1'b0) begin
         errors++;
         $display("FAIL bad_write: err=%b tdr=%h load=%b, required 1/FF/0", x_err, tdr0, load0);
      end
      xfer(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'hFF || x_err !== 1'b0) begin
         errors++;
         $display("FAIL bad_tdr_kept: data=%h err=%b, required FF/0", x_data, x_err);
      end
      xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'hB3) begin
         errors++;
         $display("FAIL bad_tcr_kept: data=%h, required B3", x_data);
      end
      xfer(1'b0, 1'b0, 8'h02, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h01) begin
         errors++;
         $display("FAIL bad_tsr_kept: data=%h, required 01", x_data);
      end
      xfer(1'b0, 1'b0, 8'h05, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h00 || x_err !== 1'b1) begin
         errors++;
         $display("FAIL bad_read: data=%h err=%b, required 00/1", x_data, x_err);
      end
   endtask

   task automatic test_back_to_back();
      xfer(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0);
      xfer(1'b0, 1'b1, 8'h01, 8'h11, 1'b0);
      checks++;
      if ({load0, en0, down0, cks0} !== 5'b01001 || x_cycles != 2) begin
         errors++;
         $display("FAIL b2b_ctrl: load=%b en=%b down=%b cks=%b cycles=%0d, required 0/1/0/01 in 2", load0, en0, down0, cks0, x_cycles);
      end
      xfer(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_tdr: data=%h, required 3C", x_data);
      end
      xfer(1'b0, 1'b0, 8'h01, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h11) begin
         errors++;
         $display("FAIL b2b_tcr: data=%h, required 11", x_data);
      end
   endtask

   task automatic test_wait_states();
      xfer(1'b1, 1'b1, 8'h00, 8'h11, 1'b0);
      checks++;
      if (x_cycles != 4 || pready2 !== 1'b0 || tdr2 !== 8'h11) begin
         errors++;
         $display("FAIL ws_write: cycles=%0d pready_after=%b tdr=%h, required 4/0/11", x_cycles, pready2, tdr2);
      end
      xfer(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (x_cycles != 4 || x_data !== 8'h11 || pready2 !== 1'b0) begin
         errors++;
         $display("FAIL ws_read: cycles=%0d data=%h pready_after=%b, required 4/11/0", x_cycles, x_data, pready2);
      end
   endtask

   task automatic test_reset_mid();
      bit saw;
      psel2   = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h00;
      pwdata  = 8'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      preset2 = 1'b1;
      @(posedge clk); #1;
      preset2 = 1'b0;
      // Hold the access phase; the completer must not resume or commit it.
      saw = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (pready2 !== 1'b0) saw = 1'b1;
      end
      @(posedge clk); #1;
      psel2   = 1'b0;
      penable = 1'b0;
      $display("xfer dut1 WR addr=00 wdata=55 interrupted by reset");
      checks++;
      if (saw !== 1'b0 || tdr2 !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: pready_seen=%b tdr=%h, required 0/00", saw, tdr2);
      end
      xfer(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      checks++;
      if (x_data !== 8'h00 || x_cycles != 4) begin
         errors++;
         $display("FAIL reset_mid_read: data=%h cycles=%0d, required 00/4", x_data, x_cycles);
      end
   endtask

   initial begin
      test_reset();
      test_ctrl_write();
      test_status();
      test_same_cycle();
      test_error();
      test_back_to_back();
      test_wait_states();
      test_reset_mid();
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
